// File: rtl/dot_accum.sv
// dot_accum: multiply-accumulate back end for the 8x8 unsigned multiplier.
// Sums LEN unsigned 16-bit products into an ACC_W-bit register. It presents
// the finished sum on a valid/ready output and holds it until the consumer
// takes it, then clears for the next sum.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ACCUM | accepting products (in_ready=1), sum still in progress
// ST_DONE  | sum complete, held on acc_out_o until out_ready_i (out_valid=1)
module dot_accum #(
    parameter int LEN   = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      prod_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] acc_out_o,
    output logic             ovf_o,
    output logic [7:0]       cnt_o
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ACC_W:0]   sum;

    // One extra bit catches the carry out of the accumulator for the sticky flag.
    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod_i};

    // Next-state and datapath update; clr wins over both handshakes.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_valid_i) begin
                        acc_d = sum[ACC_W-1:0];
                        ovf_d = ovf_q | sum[ACC_W];
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode the state register only.
    assign in_ready_o  = (state_q == ST_ACCUM);
    assign out_valid_o = (state_q == ST_DONE);
    assign acc_out_o   = acc_q;
    assign ovf_o       = ovf_q;
    assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_dot_accum.sv
// Bench for dot_accum: two instances (ACC_W=24 and ACC_W=17) share one
// stimulus stream and are compared every cycle against an arithmetic model.
module tb_dot_accum;

    localparam int LEN = 8;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, out_ready;
    logic [15:0] prod;

    logic        ir_a, ov_a, ovf_a;
    logic [23:0] acc_a;
    logic [7:0]  cnt_a;
    logic        ir_b, ov_b, ovf_b;
    logic [16:0] acc_b;
    logic [7:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the exact (unbounded) running sum and the number accepted.
    longint m_sum = 0;
    int     m_cnt = 0;

    always #5 clk = ~clk;

    dot_accum #(.LEN(LEN), .ACC_W(24)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .in_valid_i(in_valid), .in_ready_o(ir_a), .prod_i(prod),
        .out_valid_o(ov_a), .out_ready_i(out_ready),
        .acc_out_o(acc_a), .ovf_o(ovf_a), .cnt_o(cnt_a)
    );

    dot_accum #(.LEN(LEN), .ACC_W(17)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .in_valid_i(in_valid), .in_ready_o(ir_b), .prod_i(prod),
        .out_valid_o(ov_b), .out_ready_i(out_ready),
        .acc_out_o(acc_b), .ovf_o(ovf_b), .cnt_o(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic done;
        done = (m_cnt == LEN);
        chk("in_ready_a",  64'(ir_a),  64'(!done));
        chk("out_valid_a", 64'(ov_a),  64'(done));
        chk("acc_a",       64'(acc_a), 64'(m_sum % (64'd1 << 24)));
        chk("ovf_a",       64'(ovf_a), 64'(m_sum >= (64'd1 << 24)));
        chk("cnt_a",       64'(cnt_a), 64'(m_cnt));
        chk("in_ready_b",  64'(ir_b),  64'(!done));
        chk("out_valid_b", 64'(ov_b),  64'(done));
        chk("acc_b",       64'(acc_b), 64'(m_sum % (64'd1 << 17)));
        chk("ovf_b",       64'(ovf_b), 64'(m_sum >= (64'd1 << 17)));
        chk("cnt_b",       64'(cnt_b), 64'(m_cnt));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after it.
    task automatic cyc(input bit v, input logic [15:0] p, input bit r,
                       input bit c, input bit rs);
        in_valid  = v;
        prod      = p;
        out_ready = r;
        clr       = c;
        rst       = rs;
        @(posedge clk);
        if (rs || c) begin
            m_sum = 0;
            m_cnt = 0;
        end else if (m_cnt == LEN) begin
            if (r) begin
                m_sum = 0;
                m_cnt = 0;
            end
        end else if (v) begin
            m_sum += longint'(p);
            m_cnt++;
        end
        #1;
        check_all();
    endtask

    initial begin
        int gap;
        in_valid = 1'b0; prod = '0; out_ready = 1'b0; clr = 1'b0; rst = 1'b1;

        // Reset with in_valid high: nothing may accumulate.
        cyc(1, 16'd500, 1, 0, 1);
        cyc(1, 16'd500, 1, 0, 1);
        chk("reset_in_ready", 64'(ir_a), 64'd1);
        chk("reset_acc", 64'(acc_a), 64'd0);

        // Basic sum: 8 x 3358 back to back, consumer always ready.
        for (int i = 0; i < LEN; i++) cyc(1, 16'd3358, 1, 0, 0);
        chk("basic_sum", 64'(acc_a), 64'd26864);
        chk("basic_cnt", 64'(cnt_a), 64'd8);
        chk("basic_valid", 64'(ov_a), 64'd1);
        cyc(0, 16'd0, 1, 0, 0);
        chk("basic_ready_back", 64'(ir_a), 64'd1);
        chk("basic_cleared", 64'(acc_a), 64'd0);

        // Backpressure: hold DONE for 5 cycles with a product still offered.
        for (int i = 0; i < LEN; i++) cyc(1, 16'd3358, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 16'd3358, 0, 0, 0);
            chk("bp_hold_acc", 64'(acc_a), 64'd26864);
            chk("bp_hold_ready", 64'(ir_a), 64'd0);
        end
        cyc(1, 16'd3358, 1, 0, 0);
        cyc(1, 16'd3358, 0, 0, 0);
        chk("bp_ninth_accepted", 64'(acc_a), 64'd3358);
        cyc(0, 16'd0, 0, 1, 0);

        // Overflow: 8 x 65025 wraps the 17-bit instance.
        for (int i = 0; i < LEN; i++) cyc(1, 16'd65025, 0, 0, 0);
        chk("ovf17_acc", 64'(acc_b), 64'd126984);
        chk("ovf17_flag", 64'(ovf_b), 64'd1);
        chk("ovf24_acc", 64'(acc_a), 64'd520200);
        cyc(0, 16'd0, 1, 0, 0);
        chk("ovf17_cleared", 64'(ovf_b), 64'd0);

        // Gaps: values 1..8 separated by 0-3 idle cycles.
        for (int i = 1; i <= LEN; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) cyc(0, 16'($urandom), 1, 0, 0);
            cyc(1, 16'(i), 1, 0, 0);
            chk("gap_cnt_step", 64'(cnt_a), 64'(i));
        end
        chk("gap_sum", 64'(acc_a), 64'd36);
        cyc(0, 16'd0, 1, 0, 0);

        // clr mid-sum drops the product offered with it.
        for (int i = 0; i < 3; i++) cyc(1, 16'd100, 1, 0, 0);
        cyc(1, 16'd50, 1, 1, 0);
        chk("clr_acc", 64'(acc_a), 64'd0);
        chk("clr_cnt", 64'(cnt_a), 64'd0);
        for (int i = 0; i < LEN; i++) cyc(1, 16'd10, 0, 0, 0);
        chk("clr_then_sum", 64'(acc_a), 64'd80);
        cyc(0, 16'd0, 0, 1, 0);
        chk("clr_in_done", 64'(ov_a), 64'd0);

        // rst mid-sum, then rst while DONE.
        for (int i = 0; i < 5; i++) cyc(1, 16'd777, 0, 0, 0);
        cyc(1, 16'd777, 0, 0, 1);
        cyc(1, 16'd777, 0, 0, 1);
        chk("rst_mid_acc", 64'(acc_a), 64'd0);
        chk("rst_mid_ready", 64'(ir_a), 64'd1);
        for (int i = 0; i < LEN; i++) cyc(1, 16'd777, 0, 0, 0);
        cyc(1, 16'd777, 0, 0, 1);
        chk("rst_done_valid", 64'(ov_a), 64'd0);
        chk("rst_done_cnt", 64'(cnt_a), 64'd0);

        // Random traffic with occasional clr and rst.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, 16'($urandom),
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 40) == 0,
                $urandom_range(0, 80) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
